// File: rtl/alu_serial_seq.sv
// alu_serial_seq -- bit-serial N-bit ALU sequencer.
//
// Runs a full-width NOR/XOR/ADD/SUB through a single 1-bit ALU slice,
// one bit per clock, LSB first. The slice carry-out is fed back through a
// carry register. The result and flags are assembled in internal
// registers. They are published to the outputs, together with a done
// pulse, when the operation finishes.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   operation request, sampled only while idle
//   op      in   2-bit opcode: 00=NOR 01=XOR 10=ADD 11=SUB (a-b)
//   a, b    in   N-bit operands, captured on an accepted start
//   busy    out  high while the operation is running or finishing
//   done    out  one-cycle pulse; result/flags are valid from this cycle
//   result  out  N-bit result, held until the next completion
//   cout    out  final carry-out (ADD/SUB only)
//   ovf     out  signed overflow (ADD/SUB only)
//   zero    out  result == 0

// One-bit ALU slice. SUB uses the inverted b; the +1 comes from the caller's carry seed.
module alu1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);
  logic bx;

  always_comb begin
    bx   = b ^ op[0];
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      2'b00:   s = ~(a | b);
      2'b01:   s = a ^ b;
      default: begin
        s    = a ^ bx ^ cin;
        cout = (a & bx) | (a & cin) | (bx & cin);
      end
    endcase
  end
endmodule

module alu_serial_seq #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_sh_q, a_sh_d;
  logic [N-1:0]    b_sh_q, b_sh_d;
  logic [N-1:0]    res_sh_q, res_sh_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic            cmsb_q, cmsb_d;
  logic [N-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;
  logic            done_q, done_d;

  logic            slice_s;
  logic            slice_cout;

  alu1bit u_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          cnt_d   = '0;
          // SUB is a + ~b + 1: the +1 enters as the initial carry.
          carry_d = (op == 2'b11);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        res_sh_d = {slice_s, res_sh_q[N-1:1]};
        carry_d  = slice_cout;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          // Carry into the MSB, needed for signed overflow.
          cmsb_d  = carry_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        result_d = res_sh_q;
        cout_d   = op_q[1] & carry_q;
        ovf_d    = op_q[1] & (carry_q ^ cmsb_q);
        zero_d   = (res_sh_q == '0);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q == S_RUN) || (state_q == S_DONE);
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq (N=8): a vector table of operations
// with hand-computed results, plus sequences for ignored starts, a held
// start, and asynchronous reset in mid-operation.
module tb_alu_serial_seq;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] op = 2'b00;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, cout, ovf, zero;
  logic [7:0] result;

  int n_pass = 0;
  int n_total = 0;

  alu_serial_seq #(.N(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue one request and wait (bounded) for done. Cycle c is the clock
  // period following the c-th edge after the request is driven.
  task automatic do_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                       output int lat, output int busy_cnt, output logic [7:0] held_r);
    lat = 0;
    busy_cnt = 0;
    held_r = 8'h00;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 8'hxx; b = 8'hxx;
    for (int c = 1; c <= 20; c++) begin
      if (c == 1) held_r = result;
      if (busy) busy_cnt++;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) $display("FAIL do_op timeout: no done within 20 cycles");
  endtask

  initial begin
    int lat, bc, d1, d2, ndone;
    logic [7:0] held, prev_res, res_at_done;

    vecs[0] = '{2'b10, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{2'b11, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b11, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{2'b00, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{2'b01, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{2'b11, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_outs", {result, cout, ovf, zero}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    prev_res = 8'h00;
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc, held);
      chk($sformatf("v%0d_latency", i), lat, 10);
      chk($sformatf("v%0d_busy_cycles", i), bc, 9);
      chk($sformatf("v%0d_held_result", i), held, prev_res);
      chk($sformatf("v%0d_result", i), result, vecs[i].res);
      chk($sformatf("v%0d_cout", i), cout, vecs[i].co);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
      chk($sformatf("v%0d_zero", i), zero, vecs[i].z);
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_result_hold", i), result, vecs[i].res);
      prev_res = vecs[i].res;
    end

    // Start pulsed during run cycle 3 must be ignored
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = 2'b11; a = 8'h09; b = 8'h02;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    res_at_done = 8'h00;
    for (int c = 0; c < 20; c++) begin
      if (done) begin
        ndone++;
        res_at_done = result;
      end
      @(negedge clk);
    end
    chk("ignored_start_dones", ndone, 1);
    chk("ignored_start_result", res_at_done, 8'h02);

    // Start held high: accepts only in IDLE, one op per 10 cycles
    start = 1'b1; op = 2'b10; a = 8'h01; b = 8'h02;
    d1 = 0; d2 = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 == 0) d1 = c;
        else if (d2 == 0) d2 = c;
      end
    end
    start = 1'b0;
    chk("held_first_done", d1, 10);
    chk("held_second_done", d2, 20);
    chk("held_result", result, 8'h03);
    repeat (12) @(negedge clk);

    // Asynchronous reset during run cycle 4
    start = 1'b1; op = 2'b10; a = 8'hFF; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_outs", {done, result, cout, ovf, zero}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    bc = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done) ndone++;
      if (busy) bc++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", bc, 0);
    do_op(2'b10, 8'h02, 8'h03, lat, bc, held);
    chk("post_reset_latency", lat, 10);
    chk("post_reset_result", result, 8'h05);
    chk("post_reset_flags", {cout, ovf, zero}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
